// File: rtl/dram_wr_pkg.sv
// Shared types and constants for the CIM DRAM write-bit-line write controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dram_wr_pkg;

   localparam int NUM_SUBARRAY = 16;
   localparam int WORD_W       = 64;

   // Default phase lengths in cycles
   localparam int T_PRE_D = 4;
   localparam int T_WR_D  = 8;
   localparam int T_REC_D = 2;

   // One-hot bit positions of the sequencer state
   localparam int ST_IDLE_B  = 0;
   localparam int ST_PRE_B   = 1;
   localparam int ST_WRITE_B = 2;
   localparam int ST_REC_B   = 3;
   localparam int ST_DONE_B  = 4;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001 << ST_IDLE_B,
      S_PRE   = 5'b00001 << ST_PRE_B,
      S_WRITE = 5'b00001 << ST_WRITE_B,
      S_REC   = 5'b00001 << ST_REC_B,
      S_DONE  = 5'b00001 << ST_DONE_B
   } state_e;

   typedef logic [WORD_W-1:0] word_t;

   // Completed-write counter saturates at one full 64-row pass
   localparam logic [6:0] WR_CNT_MAX = 7'd64;

endpackage

// File: rtl/dram_phase_timer.sv
// Loadable 8-bit down-counter timing one sequencer phase; expire is high when the count is 0.
// Latency: load takes effect at the next edge; expire follows the registered count.
// Backpressure: none; free-running decrement to 0, holds at 0.
// Ports: CLK/RSTn clock and async active-low reset; load/load_val reload; expire phase end.
module dram_phase_timer
   import dram_wr_pkg::*;
(
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       expire
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == 8'd0);

endmodule

// File: rtl/dram_wbl_write_ctrl.sv
// Latches one row write (address + 16 WBL words) per IO_EN and sequences the macro PRE -> WRITE -> REC -> DONE.
// Latency: wr_done in the cycle starting T_PRE+T_WR+T_REC edges after acceptance.
// Backpressure: none; IO_EN outside IDLE/DONE is dropped and flagged on sticky OVR.
// Ports: CLK/RSTn; IO_EN, ADDR, WBL_DATA1..16 request; wr_done, BUSY, OVR, WR_CNT status;
//        D_ADDR, D_PRE, D_WL_EN, D_WBL_EN, D_WBL1..16 macro drive (all registered).
module dram_wbl_write_ctrl
   import dram_wr_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int T_PRE  = T_PRE_D,
   parameter int T_WR   = T_WR_D,
   parameter int T_REC  = T_REC_D
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              IO_EN,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [63:0]       WBL_DATA1,  WBL_DATA2,  WBL_DATA3,  WBL_DATA4,
   input  logic [63:0]       WBL_DATA5,  WBL_DATA6,  WBL_DATA7,  WBL_DATA8,
   input  logic [63:0]       WBL_DATA9,  WBL_DATA10, WBL_DATA11, WBL_DATA12,
   input  logic [63:0]       WBL_DATA13, WBL_DATA14, WBL_DATA15, WBL_DATA16,
   output logic              wr_done,
   output logic              BUSY,
   output logic              OVR,
   output logic [6:0]        WR_CNT,
   output logic [ADDR_W-1:0] D_ADDR,
   output logic              D_PRE,
   output logic              D_WL_EN,
   output logic              D_WBL_EN,
   output logic [63:0]       D_WBL1,  D_WBL2,  D_WBL3,  D_WBL4,
   output logic [63:0]       D_WBL5,  D_WBL6,  D_WBL7,  D_WBL8,
   output logic [63:0]       D_WBL9,  D_WBL10, D_WBL11, D_WBL12,
   output logic [63:0]       D_WBL13, D_WBL14, D_WBL15, D_WBL16
);

   // Timer reload values: a phase of T cycles counts T-1 down to 0
   localparam logic [7:0] PRE_LD = 8'(T_PRE - 1);
   localparam logic [7:0] WR_LD  = 8'(T_WR - 1);
   localparam logic [7:0] REC_LD = 8'(T_REC - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   word_t               wbl_q [NUM_SUBARRAY];
   word_t               wbl_d [NUM_SUBARRAY];
   word_t               wbl_in [NUM_SUBARRAY];
   logic                pre_q, pre_d;
   logic                wl_en_q, wl_en_d;
   logic                wbl_en_q, wbl_en_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                ovr_q, ovr_d;
   logic [6:0]          wr_cnt_q, wr_cnt_d;
   logic                tmr_load;
   logic [7:0]          tmr_ld_val;
   logic                tmr_expire;
   logic                accept;

   assign wbl_in = '{WBL_DATA1,  WBL_DATA2,  WBL_DATA3,  WBL_DATA4,
                     WBL_DATA5,  WBL_DATA6,  WBL_DATA7,  WBL_DATA8,
                     WBL_DATA9,  WBL_DATA10, WBL_DATA11, WBL_DATA12,
                     WBL_DATA13, WBL_DATA14, WBL_DATA15, WBL_DATA16};

   dram_phase_timer u_timer (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .load     (tmr_load),
      .load_val (tmr_ld_val),
      .expire   (tmr_expire)
   );

   // A request is taken only at rest or in the DONE cycle (back-to-back writes)
   assign accept = IO_EN && (state_q == S_IDLE || state_q == S_DONE);

   always_comb begin
      state_d    = state_q;
      tmr_load   = 1'b0;
      tmr_ld_val = 8'd0;
      addr_d     = addr_q;
      wbl_d      = wbl_q;
      ovr_d      = ovr_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_PRE;
               tmr_load   = 1'b1;
               tmr_ld_val = PRE_LD;
            end
         end
         S_PRE: begin
            if (tmr_expire) begin
               state_d    = S_WRITE;
               tmr_load   = 1'b1;
               tmr_ld_val = WR_LD;
            end
         end
         S_WRITE: begin
            if (tmr_expire) begin
               state_d    = S_REC;
               tmr_load   = 1'b1;
               tmr_ld_val = REC_LD;
            end
         end
         S_REC: begin
            if (tmr_expire) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (accept) begin
               state_d    = S_PRE;
               tmr_load   = 1'b1;
               tmr_ld_val = PRE_LD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         addr_d = ADDR;
         wbl_d  = wbl_in;
      end

      if (IO_EN && (state_q == S_PRE || state_q == S_WRITE || state_q == S_REC)) begin
         ovr_d = 1'b1;
      end

      // Phase strobes are decoded from the next state so each drives straight off a flop
      pre_d    = (state_d == S_PRE);
      wl_en_d  = (state_d == S_WRITE);
      wbl_en_d = (state_d == S_WRITE) || (state_d == S_REC);
      done_d   = (state_d == S_DONE);
      busy_d   = (state_d != S_IDLE);

      wr_cnt_d = wr_cnt_q;
      if (done_q && (wr_cnt_q != WR_CNT_MAX)) begin
         wr_cnt_d = wr_cnt_q + 7'd1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wbl_q    <= '{default: '0};
         pre_q    <= 1'b0;
         wl_en_q  <= 1'b0;
         wbl_en_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovr_q    <= 1'b0;
         wr_cnt_q <= 7'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wbl_q    <= wbl_d;
         pre_q    <= pre_d;
         wl_en_q  <= wl_en_d;
         wbl_en_q <= wbl_en_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ovr_q    <= ovr_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign wr_done  = done_q;
   assign BUSY     = busy_q;
   assign OVR      = ovr_q;
   assign WR_CNT   = wr_cnt_q;
   assign D_ADDR   = addr_q;
   assign D_PRE    = pre_q;
   assign D_WL_EN  = wl_en_q;
   assign D_WBL_EN = wbl_en_q;

   assign D_WBL1  = wbl_q[0];
   assign D_WBL2  = wbl_q[1];
   assign D_WBL3  = wbl_q[2];
   assign D_WBL4  = wbl_q[3];
   assign D_WBL5  = wbl_q[4];
   assign D_WBL6  = wbl_q[5];
   assign D_WBL7  = wbl_q[6];
   assign D_WBL8  = wbl_q[7];
   assign D_WBL9  = wbl_q[8];
   assign D_WBL10 = wbl_q[9];
   assign D_WBL11 = wbl_q[10];
   assign D_WBL12 = wbl_q[11];
   assign D_WBL13 = wbl_q[12];
   assign D_WBL14 = wbl_q[13];
   assign D_WBL15 = wbl_q[14];
   assign D_WBL16 = wbl_q[15];

endmodule

// File: tb/tb_dram_wbl_write_ctrl.sv
// Directed bench for dram_wbl_write_ctrl: default-timing instance u_a plus a T=1/1/1 instance u_b.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_dram_wbl_write_ctrl;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        io_en_a = 1'b0;
   logic        io_en_b = 1'b0;
   logic [5:0]  addr_in = '0;
   logic [63:0] wbl_in [16];

   logic        a_done, a_busy, a_ovr, a_pre, a_wl, a_wbl_en;
   logic [6:0]  a_cnt;
   logic [5:0]  a_addr;
   logic [63:0] a_wbl [16];
   logic        b_done, b_busy, b_ovr, b_pre, b_wl, b_wbl_en;
   logic [6:0]  b_cnt;
   logic [5:0]  b_addr;
   logic [63:0] b_wbl [16];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   dram_wbl_write_ctrl u_a (
      .CLK(CLK), .RSTn(RSTn), .IO_EN(io_en_a), .ADDR(addr_in),
      .WBL_DATA1(wbl_in[0]),   .WBL_DATA2(wbl_in[1]),   .WBL_DATA3(wbl_in[2]),   .WBL_DATA4(wbl_in[3]),
      .WBL_DATA5(wbl_in[4]),   .WBL_DATA6(wbl_in[5]),   .WBL_DATA7(wbl_in[6]),   .WBL_DATA8(wbl_in[7]),
      .WBL_DATA9(wbl_in[8]),   .WBL_DATA10(wbl_in[9]),  .WBL_DATA11(wbl_in[10]), .WBL_DATA12(wbl_in[11]),
      .WBL_DATA13(wbl_in[12]), .WBL_DATA14(wbl_in[13]), .WBL_DATA15(wbl_in[14]), .WBL_DATA16(wbl_in[15]),
      .wr_done(a_done), .BUSY(a_busy), .OVR(a_ovr), .WR_CNT(a_cnt), .D_ADDR(a_addr),
      .D_PRE(a_pre), .D_WL_EN(a_wl), .D_WBL_EN(a_wbl_en),
      .D_WBL1(a_wbl[0]),   .D_WBL2(a_wbl[1]),   .D_WBL3(a_wbl[2]),   .D_WBL4(a_wbl[3]),
      .D_WBL5(a_wbl[4]),   .D_WBL6(a_wbl[5]),   .D_WBL7(a_wbl[6]),   .D_WBL8(a_wbl[7]),
      .D_WBL9(a_wbl[8]),   .D_WBL10(a_wbl[9]),  .D_WBL11(a_wbl[10]), .D_WBL12(a_wbl[11]),
      .D_WBL13(a_wbl[12]), .D_WBL14(a_wbl[13]), .D_WBL15(a_wbl[14]), .D_WBL16(a_wbl[15])
   );

   dram_wbl_write_ctrl #(.ADDR_W(6), .T_PRE(1), .T_WR(1), .T_REC(1)) u_b (
      .CLK(CLK), .RSTn(RSTn), .IO_EN(io_en_b), .ADDR(addr_in),
      .WBL_DATA1(wbl_in[0]),   .WBL_DATA2(wbl_in[1]),   .WBL_DATA3(wbl_in[2]),   .WBL_DATA4(wbl_in[3]),
      .WBL_DATA5(wbl_in[4]),   .WBL_DATA6(wbl_in[5]),   .WBL_DATA7(wbl_in[6]),   .WBL_DATA8(wbl_in[7]),
      .WBL_DATA9(wbl_in[8]),   .WBL_DATA10(wbl_in[9]),  .WBL_DATA11(wbl_in[10]), .WBL_DATA12(wbl_in[11]),
      .WBL_DATA13(wbl_in[12]), .WBL_DATA14(wbl_in[13]), .WBL_DATA15(wbl_in[14]), .WBL_DATA16(wbl_in[15]),
      .wr_done(b_done), .BUSY(b_busy), .OVR(b_ovr), .WR_CNT(b_cnt), .D_ADDR(b_addr),
      .D_PRE(b_pre), .D_WL_EN(b_wl), .D_WBL_EN(b_wbl_en),
      .D_WBL1(b_wbl[0]),   .D_WBL2(b_wbl[1]),   .D_WBL3(b_wbl[2]),   .D_WBL4(b_wbl[3]),
      .D_WBL5(b_wbl[4]),   .D_WBL6(b_wbl[5]),   .D_WBL7(b_wbl[6]),   .D_WBL8(b_wbl[7]),
      .D_WBL9(b_wbl[8]),   .D_WBL10(b_wbl[9]),  .D_WBL11(b_wbl[10]), .D_WBL12(b_wbl[11]),
      .D_WBL13(b_wbl[12]), .D_WBL14(b_wbl[13]), .D_WBL15(b_wbl[14]), .D_WBL16(b_wbl[15])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs and samples live 1 time unit after the rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected {busy, wr_done, pre, wl_en, wbl_en} c cycles after acceptance
   function automatic logic [4:0] exp_phase(int c, int tp, int tw, int tr);
      int tot = tp + tw + tr;
      exp_phase = {c <= tot, c == tot, c < tp, (c >= tp) && (c < tp + tw), (c >= tp) && (c < tot)};
   endfunction

   // Called right after the accepting edge; walks the whole sequence, optionally
   // injecting a stray request on instance a that is sampled at edge k+inj+1.
   task automatic run_trace(input string tag, input bit use_b, input int tp, input int tw, input int tr,
                            input int inj, input logic [5:0] exp_addr,
                            input logic [63:0] exp_w1, input logic [63:0] exp_w16);
      logic [4:0] got;
      int tot = tp + tw + tr;
      for (int c = 0; c <= tot + 1; c++) begin
         got = use_b ? {b_busy, b_done, b_pre, b_wl, b_wbl_en} : {a_busy, a_done, a_pre, a_wl, a_wbl_en};
         chk($sformatf("%s_phase_c%0d", tag, c), {59'd0, got}, {59'd0, exp_phase(c, tp, tw, tr)});
         if (c == tot) begin
            chk($sformatf("%s_addr", tag), {58'd0, use_b ? b_addr : a_addr}, {58'd0, exp_addr});
            chk($sformatf("%s_wbl1", tag), use_b ? b_wbl[0] : a_wbl[0], exp_w1);
            chk($sformatf("%s_wbl16", tag), use_b ? b_wbl[15] : a_wbl[15], exp_w16);
         end
         if (c == inj) begin
            io_en_a   = 1'b1;
            addr_in   = 6'h3F;
            wbl_in[0] = 64'hBAD0BAD0BAD0BAD0;
         end
         tick();
         io_en_a = 1'b0;
      end
   endtask

   initial begin
      int t, last, waited, seen;
      for (int i = 0; i < 16; i++) wbl_in[i] = 64'h1111_1111_1111_1111 * (i + 1);

      // Reset state
      #2;
      chk("rst_busy", {63'd0, a_busy}, 64'd0);
      chk("rst_done", {63'd0, a_done}, 64'd0);
      chk("rst_ovr", {63'd0, a_ovr}, 64'd0);
      chk("rst_cnt", {57'd0, a_cnt}, 64'd0);
      chk("rst_addr", {58'd0, a_addr}, 64'd0);
      chk("rst_wbl1", a_wbl[0], 64'd0);
      chk("rst_pre_wl", {62'd0, a_pre, a_wl}, 64'd0);
      tick();
      tick();
      RSTn = 1'b1;
      tick();

      // Single write with default timing
      addr_in    = 6'h05;
      wbl_in[0]  = 64'hDEADBEEF_00000001;
      wbl_in[15] = 64'h0123456789ABCDEF;
      io_en_a    = 1'b1;
      tick();
      io_en_a = 1'b0;
      run_trace("single", 1'b0, 4, 8, 2, -1, 6'h05, 64'hDEADBEEF_00000001, 64'h0123456789ABCDEF);
      chk("single_cnt", {57'd0, a_cnt}, 64'd1);
      chk("single_ovr", {63'd0, a_ovr}, 64'd0);

      // Stray request during PRE: flagged, ignored, timing unchanged
      addr_in   = 6'h11;
      wbl_in[0] = 64'hCAFEF00D_00000011;
      io_en_a   = 1'b1;
      tick();
      io_en_a = 1'b0;
      run_trace("ovr", 1'b0, 4, 8, 2, 2, 6'h11, 64'hCAFEF00D_00000011, 64'h0123456789ABCDEF);
      chk("ovr_flag", {63'd0, a_ovr}, 64'd1);
      chk("ovr_addr_hold", {58'd0, a_addr}, 64'h11);
      chk("ovr_cnt", {57'd0, a_cnt}, 64'd2);

      // Full pass of 64 back-to-back rows, as the initialiser drives it
      RSTn = 1'b0;
      tick();
      RSTn = 1'b1;
      tick();
      addr_in = 6'd0;
      io_en_a = 1'b1;
      tick();
      io_en_a = 1'b0;
      t = 0;
      last = 0;
      for (int a = 0; a < 64; a++) begin
         waited = 0;
         while (!a_done && waited < 40) begin
            tick();
            t++;
            waited++;
         end
         if (!a_done) begin
            chk("b2b_timeout", 64'd0, 64'd1);
            break;
         end
         chk($sformatf("b2b_addr_%0d", a), {58'd0, a_addr}, 64'(a));
         chk($sformatf("b2b_gap_%0d", a), 64'(t - last), (a == 0) ? 64'd14 : 64'd15);
         last = t;
         if (a < 63) begin
            addr_in = 6'(a + 1);
            io_en_a = 1'b1;
            tick();
            t++;
            io_en_a = 1'b0;
            chk($sformatf("b2b_pre_%0d", a), {62'd0, a_pre, a_busy}, 64'd3);
         end
      end
      tick();
      chk("pass_cnt", {57'd0, a_cnt}, 64'd64);
      chk("pass_ovr", {63'd0, a_ovr}, 64'd0);

      // One more write: counter saturates
      addr_in = 6'h07;
      io_en_a = 1'b1;
      tick();
      io_en_a = 1'b0;
      waited = 0;
      while (!a_done && waited < 40) begin
         tick();
         waited++;
      end
      chk("sat_done_seen", {63'd0, a_done}, 64'd1);
      tick();
      chk("sat_cnt", {57'd0, a_cnt}, 64'd64);

      // Minimum timing instance
      addr_in    = 6'h2B;
      wbl_in[0]  = 64'h0000_0000_0000_00B1;
      wbl_in[15] = 64'h0000_0000_0000_00B2;
      io_en_b    = 1'b1;
      tick();
      io_en_b = 1'b0;
      run_trace("fast", 1'b1, 1, 1, 1, -1, 6'h2B, 64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00B2);
      chk("fast_cnt", {57'd0, b_cnt}, 64'd1);

      // Async reset in the middle of WRITE
      addr_in = 6'h2A;
      io_en_a = 1'b1;
      tick();
      io_en_a = 1'b0;
      tick();
      io_en_a = 1'b1;
      tick();
      io_en_a = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("arst_pre_wl", {62'd0, a_wl, a_wbl_en}, 64'd3);
      chk("arst_pre_ovr", {63'd0, a_ovr}, 64'd1);
      #3;
      RSTn = 1'b0;
      #1;
      chk("arst_wl_drop", {62'd0, a_wl, a_wbl_en}, 64'd0);
      chk("arst_busy_drop", {63'd0, a_busy}, 64'd0);
      tick();
      tick();
      RSTn = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (a_done) seen++;
         tick();
      end
      chk("arst_no_done", 64'(seen), 64'd0);
      chk("arst_cnt", {57'd0, a_cnt}, 64'd0);
      chk("arst_addr", {58'd0, a_addr}, 64'd0);
      chk("arst_ovr", {63'd0, a_ovr}, 64'd0);
      chk("arst_wbl16", a_wbl[15], 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
